// File: rtl/cmd_rx_core.sv
// Command-link receiver: synchronises a forwarded serial clock/data pair, deserialises MSB-first into a
// byte capture memory and exposes status/config on the basil bus. Define CMD_RX_FRAME_CNT_EN for FRAME_COUNT.
module cmd_rx_core #(
    parameter int ABUSWIDTH = 16,
    parameter int MEM_SIZE  = 2048
) (
    input  logic                 BUS_CLK,
    input  logic                 RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 CMD_CLK_IN,
    input  logic                 CMD_DATA_IN,
    output logic                 BUSY,
    output logic                 FRAME_READY
);

    localparam int          MEM_DEPTH = MEM_SIZE - 16;
    localparam int          MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] BIT_LIMIT = 32'(MEM_DEPTH * 8);
    localparam logic [7:0]  VERSION   = 8'd1;
    localparam logic [7:0]  GAP_RESET = 8'd16;
    localparam logic [7:0]  GAP_MIN   = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RECEIVE,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        frame_ready_q, frame_ready_d;
    logic        en_q, en_d;
    logic        edge_neg_q, edge_neg_d;
    logic [7:0]  gap_q, gap_d;
    logic [2:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  dat_sync_q, dat_sync_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_mem_sel_q, rd_mem_sel_d;
    logic        soft_rst_q, soft_rst_d;
`ifdef CMD_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

    logic              rst;
    logic              wr_rearm, wr_conf, wr_gap;
    logic              edge_det, rx_bit;
    logic [7:0]        gap_eff;
    logic              capture, enter_done;
    logic [15:0]       cur_n;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_wa;
    logic [7:0]        mem_wd;
    logic              mem_hit;
    logic [MEM_AW-1:0] rd_idx;
    logic [7:0]        mem_rd_q;
    logic [7:0]        reg_rd_data;
    logic [7:0]        mem [MEM_DEPTH];

    // A write to address 0 resets the block one cycle after the write.
    assign soft_rst_d = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
    assign rst        = RST || soft_rst_q;
    assign wr_rearm   = BUS_WR && (BUS_ADD == ABUSWIDTH'(1));
    assign wr_conf    = BUS_WR && (BUS_ADD == ABUSWIDTH'(2));
    assign wr_gap     = BUS_WR && (BUS_ADD == ABUSWIDTH'(5));

    // Stages [1:0] synchronise, stage [2] provides the previous level for edge detection.
    assign clk_sync_d = {clk_sync_q[1:0], CMD_CLK_IN};
    assign dat_sync_d = {dat_sync_q[0], CMD_DATA_IN};
    assign edge_det   = edge_neg_q ? (!clk_sync_q[1] && clk_sync_q[2])
                                   : (clk_sync_q[1] && !clk_sync_q[2]);
    assign rx_bit     = dat_sync_q[1];
    assign gap_eff    = (gap_q < GAP_MIN) ? GAP_MIN : gap_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        gap_cnt_d     = gap_cnt_q;
        done_d        = done_q;
        ovf_d         = ovf_q;
        frame_ready_d = 1'b0;
        capture       = 1'b0;
        enter_done    = 1'b0;
        mem_we        = 1'b0;
        mem_wa        = bit_cnt_q[MEM_AW+2:3];
        mem_wd        = shift_q;
        cur_n         = (state_q == ST_ARMED) ? 16'd0 : bit_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (edge_det) begin
                    state_d = ST_RECEIVE;
                    capture = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (edge_det) begin
                    capture = 1'b1;
                end else if (gap_cnt_q == gap_eff) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (wr_rearm) state_d = en_q ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            shift_d   = {shift_q[6:0], rx_bit};
            gap_cnt_d = 8'd0;
            bit_cnt_d = (cur_n == 16'hFFFF) ? cur_n : cur_n + 16'd1;
            if (32'(cur_n) < BIT_LIMIT) begin
                if (cur_n[2:0] == 3'd7) begin
                    mem_we = 1'b1;
                    mem_wa = cur_n[MEM_AW+2:3];
                    mem_wd = shift_d;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end

        // The partial last byte is left-justified; the low bits of shift_q hold it.
        if (enter_done) begin
            frame_ready_d = 1'b1;
            done_d        = 1'b1;
            if ((bit_cnt_q[2:0] != 3'd0) && (32'(bit_cnt_q) < BIT_LIMIT)) begin
                mem_we = 1'b1;
                mem_wd = shift_q << (4'd8 - {1'b0, bit_cnt_q[2:0]});
            end
        end

        if (wr_rearm) begin
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            bit_cnt_d = 16'd0;
        end

        if (rst) mem_we = 1'b0;
    end

    always_comb begin
        en_d       = en_q;
        edge_neg_d = edge_neg_q;
        gap_d      = gap_q;
        if (wr_conf) {edge_neg_d, en_d} = BUS_DATA_IN[1:0];
        if (wr_gap)  gap_d = BUS_DATA_IN;
    end

`ifdef CMD_RX_FRAME_CNT_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (enter_done) frame_cnt_d = frame_cnt_q + 16'd1;
    end
`endif

    assign mem_hit = (BUS_ADD >= ABUSWIDTH'(16)) && (32'(BUS_ADD) < 32'(MEM_SIZE));
    assign rd_idx  = MEM_AW'(BUS_ADD - ABUSWIDTH'(16));

    always_comb begin
        reg_rd_data = 8'd0;
        case (BUS_ADD)
            ABUSWIDTH'(0): reg_rd_data = VERSION;
            ABUSWIDTH'(1): reg_rd_data = {5'b0, ovf_q, (state_q == ST_RECEIVE), done_q};
            ABUSWIDTH'(2): reg_rd_data = {6'b0, edge_neg_q, en_q};
            ABUSWIDTH'(3): reg_rd_data = bit_cnt_q[7:0];
            ABUSWIDTH'(4): reg_rd_data = bit_cnt_q[15:8];
            ABUSWIDTH'(5): reg_rd_data = gap_q;
`ifdef CMD_RX_FRAME_CNT_EN
            ABUSWIDTH'(6): reg_rd_data = frame_cnt_q[7:0];
            ABUSWIDTH'(7): reg_rd_data = frame_cnt_q[15:8];
`endif
            default:       reg_rd_data = 8'd0;
        endcase
        rd_data_d    = BUS_RD ? reg_rd_data : rd_data_q;
        rd_mem_sel_d = BUS_RD ? mem_hit : rd_mem_sel_q;
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) soft_rst_q <= 1'b0;
        else     soft_rst_q <= soft_rst_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 16'd0;
            shift_q       <= 8'd0;
            gap_cnt_q     <= 8'd0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            frame_ready_q <= 1'b0;
            en_q          <= 1'b0;
            edge_neg_q    <= 1'b0;
            gap_q         <= GAP_RESET;
            clk_sync_q    <= 3'd0;
            dat_sync_q    <= 2'd0;
            rd_data_q     <= 8'd0;
            rd_mem_sel_q  <= 1'b0;
`ifdef CMD_RX_FRAME_CNT_EN
            frame_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            gap_cnt_q     <= gap_cnt_d;
            done_q        <= done_d;
            ovf_q         <= ovf_d;
            frame_ready_q <= frame_ready_d;
            en_q          <= en_d;
            edge_neg_q    <= edge_neg_d;
            gap_q         <= gap_d;
            clk_sync_q    <= clk_sync_d;
            dat_sync_q    <= dat_sync_d;
            rd_data_q     <= rd_data_d;
            rd_mem_sel_q  <= rd_mem_sel_d;
`ifdef CMD_RX_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    // NOTE: the capture memory has no reset so it maps onto block RAM; its contents survive resets.
    always_ff @(posedge BUS_CLK) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (BUS_RD && mem_hit) mem_rd_q <= mem[rd_idx];
    end

    assign BUS_DATA_OUT = rd_mem_sel_q ? mem_rd_q : rd_data_q;
    assign BUSY         = (state_q == ST_RECEIVE);
    assign FRAME_READY  = frame_ready_q;

endmodule
